decrypt_v2: RTL and testbench

Iterative PRESENT-80 block decryptor: recovers a 64-bit plaintext from a 64-bit ciphertext and 80-bit key, one round per clock. It is the receive-side counterpart of the encrypt_v2 datapath and uses the same `req`/`ack` four-phase handshake and `params.h` widths. It first runs the key schedule forward to recover the final round key, then runs 31 inverse rounds while unwinding the key schedule.

---
 rtl/decrypt_v2.sv | 187 ++++++++++++++++++
 tb/tb_decrypt_v2.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decrypt_v2.sv
// Iterative PRESENT-80 decryptor: expands the key schedule forward to K32,
// then runs 31 inverse rounds while unwinding the schedule back to K1.
module decrypt_v2 #(
   parameter int N_B = 64,
   parameter int N_K = 80
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N_K-1:0] k,
   input  logic [N_B-1:0] c,
   output logic [N_B-1:0] m,
   input  logic           req,
   output logic           ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_DEC    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          r_fsm;
   state_t          w_fsm_nxt;
   logic [63:0]     r_x;
   logic [63:0]     w_x_nxt;
   logic [79:0]     r_key;
   logic [79:0]     w_key_nxt;
   logic [4:0]      r_ctr;
   logic [4:0]      w_ctr_nxt;
   logic [63:0]     r_k1;
   logic [63:0]     w_k1_nxt;
   logic            r_ack;
   logic [N_B-1:0]  r_m;

   function automatic logic [3:0] sbox(input logic [3:0] a);
      logic [3:0] y;
      case (a)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] a);
      logic [3:0] y;
      case (a)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   // Inverse bit permutation: bit j lands on 4*j mod 63, bit 63 stays put.
   function automatic logic [63:0] perm_inv(input logic [63:0] a);
      logic [63:0] y;
      logic [5:0]  s_idx;
      logic [5:0]  d_idx;
      y = 64'd0;
      for (int j = 0; j < 63; j++) begin
         s_idx    = 6'(j);
         d_idx    = 6'((4 * j) % 63);
         y[d_idx] = a[s_idx];
      end
      y[63] = a[63];
      return y;
   endfunction

   function automatic logic [63:0] dec_round(input logic [63:0] x, input logic [63:0] rk);
      logic [63:0] p;
      logic [63:0] y;
      logic [5:0]  b;
      p = perm_inv(x ^ rk);
      y = 64'd0;
      for (int n = 0; n < 16; n++) begin
         b          = 6'(4 * n);
         y[b +: 4]  = sbox_inv(p[b +: 4]);
      end
      return y;
   endfunction

   function automatic logic [79:0] key_fwd(input logic [79:0] kin, input logic [4:0] i);
      logic [79:0] t;
      t          = {kin[18:0], kin[79:19]};
      t[79:76]   = sbox(t[79:76]);
      t[19:15]   = t[19:15] ^ i;
      return t;
   endfunction

   function automatic logic [79:0] key_inv(input logic [79:0] kin, input logic [4:0] i);
      logic [79:0] t;
      t          = kin;
      t[19:15]   = t[19:15] ^ i;
      t[79:76]   = sbox_inv(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

   // Next-state and datapath update; a low req in any state aborts to IDLE.
   always_comb begin
      w_fsm_nxt = r_fsm;
      w_x_nxt   = r_x;
      w_key_nxt = r_key;
      w_ctr_nxt = r_ctr;
      w_k1_nxt  = r_k1;
      case (r_fsm)
         S_IDLE: begin
            if (req) begin
               w_x_nxt   = c;
               w_key_nxt = k;
               w_k1_nxt  = k[79:16];
               w_ctr_nxt = 5'd1;
               w_fsm_nxt = S_EXPAND;
            end else begin
               w_fsm_nxt = S_IDLE;
            end
         end
         S_EXPAND: begin
            if (!req || (r_ctr == 5'd0)) begin
               w_fsm_nxt = S_IDLE;
            end else begin
               w_key_nxt = key_fwd(r_key, r_ctr);
               if (r_ctr == 5'd31) begin
                  w_ctr_nxt = 5'd31;
                  w_fsm_nxt = S_DEC;
               end else begin
                  w_ctr_nxt = r_ctr + 5'd1;
               end
            end
         end
         S_DEC: begin
            if (!req || (r_ctr == 5'd0)) begin
               w_fsm_nxt = S_IDLE;
            end else begin
               w_x_nxt   = dec_round(r_x, r_key[79:16]);
               w_key_nxt = key_inv(r_key, r_ctr);
               if (r_ctr == 5'd1) begin
                  w_fsm_nxt = S_DONE;
               end else begin
                  w_ctr_nxt = r_ctr - 5'd1;
               end
            end
         end
         S_DONE: begin
            if (req) begin
               w_fsm_nxt = S_DONE;
            end else begin
               w_fsm_nxt = S_IDLE;
            end
         end
         default: begin
            w_fsm_nxt = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers; outputs are computed from the
   // next state so ack/m line up exactly with residency in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm <= S_IDLE;
         r_x   <= 64'd0;
         r_key <= 80'd0;
         r_ctr <= 5'd0;
         r_k1  <= 64'd0;
         r_ack <= 1'b0;
         r_m   <= '0;
      end else begin
         r_fsm <= w_fsm_nxt;
         r_x   <= w_x_nxt;
         r_key <= w_key_nxt;
         r_ctr <= w_ctr_nxt;
         r_k1  <= w_k1_nxt;
         r_ack <= (w_fsm_nxt == S_DONE);
         r_m   <= (w_fsm_nxt == S_DONE) ? (w_x_nxt ^ w_k1_nxt) : '0;
      end
   end

   assign ack = r_ack;
   assign m   = r_m;

endmodule

// File: tb/tb_decrypt_v2.sv
// Bench for decrypt_v2: known-answer table, abort/reset sequences and
// random plaintexts encrypted by a reference PRESENT-80 model.
module tb_decrypt_v2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [79:0] k;
   logic [63:0] c;
   logic [63:0] m;
   logic        ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decrypt_v2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .k     (k),
      .c     (c),
      .m     (m),
      .req   (req),
      .ack   (ack)
   );

   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   typedef struct {
      logic [79:0] k;
      logic [63:0] c;
      logic [63:0] m;
   } vec_t;

   vec_t tbl [4];

   function automatic logic [79:0] ks_next(input logic [79:0] kr, input int r);
      logic [79:0] nk;
      for (int b = 0; b < 80; b++) nk[(b + 61) % 80] = kr[b];
      nk[79:76] = SB[nk[79:76]];
      nk[19:15] = nk[19:15] ^ 5'(r);
      return nk;
   endfunction

   // Textbook PRESENT-80 encryption (what encrypt_v2 produces).
   function automatic logic [63:0] enc(input logic [79:0] key, input logic [63:0] pt);
      logic [79:0] kr;
      logic [63:0] s;
      logic [63:0] t;
      kr = key;
      s  = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kr[79:16];
         for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
         for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
         kr = ks_next(kr, r);
      end
      return s ^ kr[79:16];
   endfunction

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Full transaction from a negedge: latency, result, hold, and release.
   task automatic do_txn(input logic [79:0] kk, input logic [63:0] cc, input logic [63:0] mexp);
      int n;
      k   = kk;
      c   = cc;
      req = 1'b1;
      @(negedge clk);
      k = {$urandom(), $urandom(), 16'($urandom())};
      c = {$urandom(), $urandom()};
      n = 0;
      while (ack !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 80'(n), 80'd62);
      chk("m", 80'(m), 80'(mexp));
      chk("key_done", dut.r_key, kk);
      repeat (3) @(negedge clk);
      chk("m_hold", 80'(m), 80'(mexp));
      chk("ack_hold", 80'(ack), 80'd1);
      req = 1'b0;
      @(negedge clk);
      chk("ack_drop", 80'(ack), 80'd0);
      chk("m_drop", 80'(m), 80'd0);
   endtask

   initial begin
      logic [79:0] kk;
      logic [63:0] pt;
      int          n;

      tbl[0] = '{k: 80'h0, c: 64'h5579C1387B228445, m: 64'h0};
      tbl[1] = '{k: 80'hFFFFFFFFFFFFFFFFFFFF, c: 64'hE72C46C0F5945049, m: 64'h0};
      tbl[2] = '{k: 80'h0, c: 64'hA112FFC72F68417B, m: 64'hFFFFFFFFFFFFFFFF};
      tbl[3] = '{k: 80'hFFFFFFFFFFFFFFFFFFFF, c: 64'h3333DCD3213210D2, m: 64'hFFFFFFFFFFFFFFFF};

      rst_n = 1'b0;
      req   = 1'b0;
      k     = 80'd0;
      c     = 64'd0;
      #1;
      chk("rst_ack", 80'(ack), 80'd0);
      chk("rst_m", 80'(m), 80'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ack", 80'(ack), 80'd0);

      for (int i = 0; i < 4; i++) do_txn(tbl[i].k, tbl[i].c, tbl[i].m);

      // Abort during EXPAND (edge E20) and during DEC (edge E45).
      k = tbl[1].k;  c = tbl[1].c;  req = 1'b1;
      repeat (20) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("abort_exp_ack", 80'(ack), 80'd0);
      req = 1'b1;
      repeat (45) @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_dec_ack", 80'(ack), 80'd0);
      end
      do_txn(tbl[2].k, tbl[2].c, tbl[2].m);

      // Asynchronous reset mid-DEC, cleared without a clock edge.
      k = tbl[3].k;  c = tbl[3].c;  req = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk("rst_dec_ack", 80'(ack), 80'd0);
      chk("rst_dec_m", 80'(m), 80'd0);
      chk("rst_dec_ctr", 80'(dut.r_ctr), 80'd0);
      chk("rst_dec_x", 80'(dut.r_x), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(tbl[3].k, tbl[3].c, tbl[3].m);

      // Asynchronous reset while DONE holds a nonzero result.
      k = tbl[2].k;  c = tbl[2].c;  req = 1'b1;
      n = 0;
      while (ack !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_m", 80'(m), 80'(tbl[2].m));
      #2;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk("rst_done_ack", 80'(ack), 80'd0);
      chk("rst_done_m", 80'(m), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 500; i++) begin
         kk = {$urandom(), $urandom(), 16'($urandom())};
         pt = {$urandom(), $urandom()};
         do_txn(kk, enc(kk, pt), pt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
